cipher_decrypt: RTL

Multi-cycle decryptor that inverts the team's 256-bit block encryption, recovering the 248-bit plaintext from a 256-bit ciphertext and its two 64-bit subkeys. It sits on the receive side of the link. Ciphertext and subkeys (from the shared keygen block) are accepted on a valid/ready handshake, and the three encryption rounds are undone in reverse order, one per clock. The recovered plaintext and pad byte are presented on a second valid/ready handshake.

---
 rtl/cipher_decrypt_if.sv | 17 +
 rtl/cipher_decrypt.sv | 80 ++++++++
 2 files changed

// File: rtl/cipher_decrypt_if.sv
// cipher_decrypt_if: ciphertext/subkey input handshake and plaintext output handshake.
interface cipher_decrypt_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] cipher_text;
  logic [63:0]  key1;
  logic [63:0]  key2;
  logic         out_valid;
  logic         out_ready;
  logic [247:0] plain_text;
  logic [7:0]   pad_byte;
  logic         pad_err;
  modport master (output in_valid, cipher_text, key1, key2, out_ready,
                  input in_ready, out_valid, plain_text, pad_byte, pad_err);
  modport slave  (input in_valid, cipher_text, key1, key2, out_ready,
                  output in_ready, out_valid, plain_text, pad_byte, pad_err);
endinterface

// File: rtl/cipher_decrypt.sv
// cipher_decrypt: undoes the three encryption rounds, one per clock (xor, word rotation, bit rotation).
// Optional pad byte check enabled by defining DECRYPT_PAD_CHECK_EN.
module cipher_decrypt #(
  parameter logic [7:0] PAD_VALUE = 8'h00
) (
  input logic clk,
  input logic rst,
  cipher_decrypt_if.slave bus
);
  typedef enum logic [2:0] {IDLE, UNXOR, UNPERM, UNROT, DONE} state_t;
  state_t state_q, state_d;
  logic [255:0] d_q, d_d, rot;
  logic [63:0] k1_q, k1_d, k2_q, k2_d;
  logic out_valid_q, out_valid_d, pad_err_q, pad_err_d;
  for (genvar w = 0; w < 4; w++) begin : g_rot
    assign rot[64*w +: 64] = {d_q[64*w], d_q[64*w+1 +: 63]};
  end
  always_comb begin
    state_d = state_q;
    d_d = d_q;
    k1_d = k1_q;
    k2_d = k2_q;
    out_valid_d = out_valid_q;
    pad_err_d = pad_err_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        d_d = bus.cipher_text;
        k1_d = bus.key1;
        k2_d = bus.key2;
        state_d = UNXOR;
      end
      UNXOR: begin
        d_d = d_q ^ {4{k2_q}};
        state_d = UNPERM;
      end
      UNPERM: begin
        d_d = {d_q[63:0] ^ k1_q, d_q[255:64]};
        state_d = UNROT;
      end
      UNROT: begin
        d_d = rot;
        out_valid_d = 1'b1;
`ifdef DECRYPT_PAD_CHECK_EN
        pad_err_d = rot[255:248] != PAD_VALUE;
`else
        pad_err_d = 1'b0;
`endif
        state_d = DONE;
      end
      DONE: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        pad_err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      d_q <= '0;
      k1_q <= '0;
      k2_q <= '0;
      out_valid_q <= 1'b0;
      pad_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q <= d_d;
      k1_q <= k1_d;
      k2_q <= k2_d;
      out_valid_q <= out_valid_d;
      pad_err_q <= pad_err_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.plain_text = d_q[247:0];
  assign bus.pad_byte = d_q[255:248];
  assign bus.pad_err = pad_err_q;
endmodule
